fpu_ret_collect: RTL and testbench
==================================

// Module: fpu_ret_collect
// PURPOSE
//  Retire-side sink for FP unit completion words. Accepts up to three 14-bit ret words per cycle
//  from issue ports u1/u3/u5 (post L|H merge) and queues them in order into a FIFO.
//  Drains one entry per cycle to retire logic over a valid/ready handshake.
//  Accumulates sticky IEEE exception flags and back-pressures issue via stall.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >=4
//  CNTW    4   count width = $clog2(DEPTH)+1
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-low reset
//  u1_ret     in   14     port-1 ret word; [5:0] = {denorm,inexact,underflow,overflow,divzero,invalid}
//  u1_ret_en  in   1      u1_ret valid this cycle
//  u3_ret     in   14     port-3 ret word, same format
//  u3_ret_en  in   1      u3_ret valid
//  u5_ret     in   14     port-5 ret word, same format
//  u5_ret_en  in   1      u5_ret valid
//  out_ret    out  16     head entry {port_id[1:0], ret[13:0]}; port_id 0=u1, 1=u3, 2=u5
//  out_vld    out  1      head entry valid
//  out_rdy    in   1      retire consumes head when out_vld&out_rdy
//  stall      out  1      registered; 1 when free slots < 3
//  flags      out  6      sticky OR of ret[5:0] of every accepted entry
//  flag_clr   in   1      clear flags (pulse)
//  ovf        out  1      sticky: an enabled ret word was dropped; cleared only by reset
//  count      out  CNTW   occupied entries
// BEHAVIOUR
//  - Reset (rst=0, async): wr/rd pointers=0, count=0, out_vld=0, out_ret=0, stall=0, flags=0, ovf=0.
//  - Push order within a cycle: u1, then u3, then u5; enabled words take consecutive slots.
//  - Accept limit = DEPTH-count at cycle start; a same-cycle pop does NOT add capacity.
//    Excess enabled words (later in push order) are dropped; ovf<=1.
//  - Pop: out_vld&out_rdy -> rd_ptr+1, count-1. out_vld = (count!=0); out_ret = mem[rd_ptr] (registered).
//  - count_next = count + accepted - popped; pointers wrap modulo DEPTH.
//  - Push-to-out_vld latency 1 cycle (entry written at edge N, visible at N+1).
//  - stall_next = (DEPTH - count_next) < 3; upstream must not assert *_ret_en while stall=1.
//  - flags_next = (flag_clr ? 0 : flags) | OR(ret[5:0] of accepted words).
//    flag_clr and an accepting push in the same cycle: the new bits survive.
//  - out_vld=0 & out_rdy=1: no effect. Full & pop & push: only pop-freed capacity is withheld;
//    excess pushes are dropped and ovf<=1.
//  - Reset mid-operation: all queued entries are discarded; no partial state survives.
// CONFIGURATION
//  FPRET_BYPASS_EN defined: when count==0 and exactly one *_ret_en is high, out_vld=1 and
//    out_ret = that word combinationally in the same cycle.
//    If out_rdy=1, the word is consumed and not written; flags still update.
//    If out_rdy=0, it is enqueued normally.
//  FPRET_BYPASS_EN undefined: out_vld/out_ret purely registered; latency always 1 cycle.
// TESTING
//  1. Reset, u1_ret=14'h0011 en -> next cycle out_vld=1, out_ret=16'h0011, count=1, flags=6'h11.
//  2. u1,u3,u5 en (14'h1,14'h2,14'h4), out_rdy=0 -> out_ret sequence 0x0001,0x4002,0x8004; flags=6'h07.
//  3. DEPTH=8: fill to 6 -> stall=1; fill to 8, then push u1+u3 -> both dropped, ovf=1, count=8.
//  4. Full, out_rdy=1, push u1 -> pop occurs, u1 dropped, ovf=1, count=7.
//  5. flags=6'h3F, flag_clr with accepted ret[5:0]=6'h20 -> flags=6'h20.
//  6. FPRET_BYPASS_EN, empty, out_rdy=1, u5_ret=14'h0100 -> same-cycle out_ret=16'h8100, count stays 0.
//     Assert rst low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/fpu_ret_collect_if.sv
// Bus bundle between FP completion ports, the retire collector and the retire consumer.
// Handshake: an entry moves when out_vld & out_rdy at a rising edge; out_vld never waits on out_rdy.
interface fpu_ret_collect_if #(
    parameter int CNTW = 4
);
    logic [13:0]     u1_ret;
    logic            u1_ret_en;
    logic [13:0]     u3_ret;
    logic            u3_ret_en;
    logic [13:0]     u5_ret;
    logic            u5_ret_en;
    logic [15:0]     out_ret;
    logic            out_vld;
    logic            out_rdy;
    logic            stall;
    logic [5:0]      flags;
    logic            flag_clr;
    logic            ovf;
    logic [CNTW-1:0] count;

    modport master (
        output u1_ret, u1_ret_en, u3_ret, u3_ret_en, u5_ret, u5_ret_en, out_rdy, flag_clr,
        input  out_ret, out_vld, stall, flags, ovf, count
    );

    modport slave (
        input  u1_ret, u1_ret_en, u3_ret, u3_ret_en, u5_ret, u5_ret_en, out_rdy, flag_clr,
        output out_ret, out_vld, stall, flags, ovf, count
    );
endinterface

// File: rtl/fpu_ret_collect.sv
// Retire-side collector: up to three FP ret words per cycle into an in-order FIFO, one drained per cycle.
// Optional FPRET_BYPASS_EN: a lone word arriving at an empty FIFO is presented combinationally.
module fpu_ret_collect #(
    parameter int DEPTH = 8,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    fpu_ret_collect_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count_q;
    logic            out_vld_q;
    logic [15:0]     out_ret_q;
    logic            stall_q;
    logic [5:0]      flags_q;
    logic            ovf_q;

    logic [13:0]     ret_v [3];
    logic [2:0]      en_v;

    logic            we    [3];
    logic [AW-1:0]   waddr [3];
    logic [15:0]     wdata [3];
    logic [1:0]      n_acc;
    logic            ovf_set;
    logic [5:0]      flag_acc;
    logic            byp;
    logic [15:0]     byp_word;
    logic            pop;
    logic [CNTW-1:0] free_now;
    logic [CNTW-1:0] count_nx;
    logic [AW-1:0]   rd_ptr_nx;
    logic [15:0]     head_nx;

    assign ret_v[0] = bus.u1_ret;
    assign ret_v[1] = bus.u3_ret;
    assign ret_v[2] = bus.u5_ret;
    assign en_v     = {bus.u5_ret_en, bus.u3_ret_en, bus.u1_ret_en};

    assign pop      = out_vld_q & bus.out_rdy;
    assign free_now = CNTW'(DEPTH) - count_q;

    always_comb begin
        n_acc    = '0;
        ovf_set  = 1'b0;
        flag_acc = '0;
        byp      = 1'b0;
        byp_word = '0;
        for (int k = 0; k < 3; k++) begin
            we[k]    = 1'b0;
            waddr[k] = wr_ptr;
            wdata[k] = '0;
        end
`ifdef FPRET_BYPASS_EN
        // Reset gates the bypass so outputs drop to zero as soon as rst falls.
        if (rst && (count_q == '0) && (en_v == 3'b001 || en_v == 3'b010 || en_v == 3'b100)) begin
            byp = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            if (en_v[k]) byp_word = {2'(k), ret_v[k]};
        end
`endif
        // Capacity is judged against the count at cycle start; a same-cycle pop frees nothing.
        for (int k = 0; k < 3; k++) begin
            if (en_v[k]) begin
                if (CNTW'(n_acc) < free_now) begin
                    flag_acc = flag_acc | ret_v[k][5:0];
                    if (!(byp && bus.out_rdy)) begin
                        we[k]    = 1'b1;
                        waddr[k] = wr_ptr + AW'(n_acc);
                        wdata[k] = {2'(k), ret_v[k]};
                        n_acc    = n_acc + 2'd1;
                    end
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    assign count_nx  = count_q + CNTW'(n_acc) - CNTW'(pop);
    assign rd_ptr_nx = rd_ptr + AW'(pop);

    // Next head may be a slot written on this very edge, so forward the write data.
    always_comb begin
        head_nx = mem[rd_ptr_nx];
        for (int k = 0; k < 3; k++) begin
            if (we[k] && (waddr[k] == rd_ptr_nx)) head_nx = wdata[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (we[k]) mem[waddr[k]] <= wdata[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            out_ret_q <= '0;
            stall_q   <= 1'b0;
            flags_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(n_acc);
            rd_ptr    <= rd_ptr_nx;
            count_q   <= count_nx;
            out_vld_q <= (count_nx != '0);
            out_ret_q <= (count_nx != '0) ? head_nx : 16'h0000;
            stall_q   <= (CNTW'(DEPTH) - count_nx) < CNTW'(3);
            flags_q   <= (bus.flag_clr ? 6'h00 : flags_q) | flag_acc;
            ovf_q     <= ovf_q | ovf_set;
        end
    end

    assign bus.out_vld = out_vld_q | byp;
    assign bus.out_ret = byp ? byp_word : out_ret_q;
    assign bus.stall   = stall_q;
    assign bus.flags   = flags_q;
    assign bus.ovf     = ovf_q;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_fpu_ret_collect.sv
// Self-checking bench for fpu_ret_collect: directed cases then random traffic against a queue model.
// Build with +define+FPRET_BYPASS_EN to cover the same-cycle bypass path as well.
module tb_fpu_ret_collect;
    localparam int DEPTH = 8;
    localparam int CNTW  = 4;

    logic clk;
    logic rst;
    fpu_ret_collect_if #(.CNTW(CNTW)) bus ();

    fpu_ret_collect #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [5:0]  m_flags;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single enabled word while the queue is empty is what the bypass path presents.
    function automatic bit bypass_vis(input logic [2:0] en);
`ifdef FPRET_BYPASS_EN
        return (exp_q.size() == 0) && ($countones(en) == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge(input logic [2:0] en, input logic [13:0] a, input logic [13:0] b,
                              input logic [13:0] c, input logic rdy, input logic clr);
        logic [13:0] rw [3];
        int cap;
        int acc;
        bit byp;
        rw[0] = a; rw[1] = b; rw[2] = c;
        cap = DEPTH - exp_q.size();
        acc = 0;
        byp = bypass_vis(en) && rdy;
        if (clr) m_flags = '0;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            if (en[k]) begin
                if (byp) begin
                    m_flags = m_flags | rw[k][5:0];
                end else if (acc < cap) begin
                    exp_q.push_back({2'(k), rw[k]});
                    m_flags = m_flags | rw[k][5:0];
                    acc++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".vld"}, bus.out_vld, exp_q.size() != 0);
        if (exp_q.size() != 0) chk({tag, ".ret"}, bus.out_ret, exp_q[0]);
        chk({tag, ".count"}, bus.count, exp_q.size());
        chk({tag, ".stall"}, bus.stall, (DEPTH - exp_q.size()) < 3);
        chk({tag, ".flags"}, bus.flags, m_flags);
        chk({tag, ".ovf"}, bus.ovf, m_ovf);
    endtask

    task automatic idle_inputs();
        bus.u1_ret_en = 1'b0; bus.u3_ret_en = 1'b0; bus.u5_ret_en = 1'b0;
        bus.flag_clr  = 1'b0;
    endtask

    // Called just after a rising edge; drives one cycle, checks the pre-edge view, then the post-edge state.
    task automatic step(input logic [2:0] en, input logic [13:0] a, input logic [13:0] b,
                        input logic [13:0] c, input logic rdy, input logic clr, input string tag);
        logic [15:0] byp_word;
        bit vis;
        bus.u1_ret = a; bus.u3_ret = b; bus.u5_ret = c;
        bus.u1_ret_en = en[0]; bus.u3_ret_en = en[1]; bus.u5_ret_en = en[2];
        bus.out_rdy = rdy; bus.flag_clr = clr;
        #1;
        vis = bypass_vis(en);
        byp_word = en[0] ? {2'd0, a} : (en[1] ? {2'd1, b} : {2'd2, c});
        chk({tag, ".pre_vld"}, bus.out_vld, (exp_q.size() != 0) || vis);
        if (vis) chk({tag, ".pre_ret"}, bus.out_ret, byp_word);
        else if (exp_q.size() != 0) chk({tag, ".pre_ret"}, bus.out_ret, exp_q[0]);
        @(posedge clk);
        model_edge(en, a, b, c, rdy, clr);
        #1;
        idle_inputs();
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        bus.out_rdy = 1'b0;
        bus.u1_ret = '0; bus.u3_ret = '0; bus.u5_ret = '0;
        exp_q.delete();
        m_flags = '0;
        m_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        do_reset();
        chk("reset.vld",   bus.out_vld, 1'b0);
        chk("reset.ret",   bus.out_ret, 16'h0000);
        chk("reset.count", bus.count,   4'd0);
        chk("reset.stall", bus.stall,   1'b0);
        chk("reset.flags", bus.flags,   6'h00);
        chk("reset.ovf",   bus.ovf,     1'b0);

        // Single push becomes visible one cycle later.
        step(3'b001, 14'h0011, 14'h0, 14'h0, 1'b0, 1'b0, "t1");
        chk("t1.ret_const",   bus.out_ret, 16'h0011);
        chk("t1.count_const", bus.count,   4'd1);
        chk("t1.flags_const", bus.flags,   6'h11);

        // Three ports in one cycle keep u1, u3, u5 order.
        do_reset();
        step(3'b111, 14'h0001, 14'h0002, 14'h0004, 1'b0, 1'b0, "t2.push");
        chk("t2.flags_const", bus.flags, 6'h07);
        chk("t2.head0", bus.out_ret, 16'h0001);
        step(3'b000, 14'h0, 14'h0, 14'h0, 1'b1, 1'b0, "t2.pop0");
        chk("t2.head1", bus.out_ret, 16'h4002);
        step(3'b000, 14'h0, 14'h0, 14'h0, 1'b1, 1'b0, "t2.pop1");
        chk("t2.head2", bus.out_ret, 16'h8004);
        step(3'b000, 14'h0, 14'h0, 14'h0, 1'b1, 1'b0, "t2.pop2");

        // Fill, stall threshold, overflow drop, then full+pop+push.
        do_reset();
        step(3'b111, 14'h0100, 14'h0101, 14'h0102, 1'b0, 1'b0, "t3.f3");
        step(3'b111, 14'h0103, 14'h0104, 14'h0105, 1'b0, 1'b0, "t3.f6");
        chk("t3.stall6", bus.stall, 1'b1);
        step(3'b011, 14'h0106, 14'h0107, 14'h0, 1'b0, 1'b0, "t3.f8");
        chk("t3.count8", bus.count, 4'd8);
        chk("t3.ovf_before", bus.ovf, 1'b0);
        step(3'b011, 14'h0200, 14'h0201, 14'h0, 1'b0, 1'b0, "t3.drop");
        chk("t3.ovf_set", bus.ovf, 1'b1);
        chk("t3.count_hold", bus.count, 4'd8);
        step(3'b001, 14'h0300, 14'h0, 14'h0, 1'b1, 1'b0, "t4.fullpop");
        chk("t4.count7", bus.count, 4'd7);
        chk("t4.ovf", bus.ovf, 1'b1);
        chk("t4.head", bus.out_ret, 16'h4101);

        // Clear and accept in the same cycle keeps only the new bits.
        do_reset();
        step(3'b001, 14'h003F, 14'h0, 14'h0, 1'b0, 1'b0, "t5.set");
        chk("t5.flags3f", bus.flags, 6'h3F);
        step(3'b010, 14'h0, 14'h0020, 14'h0, 1'b0, 1'b1, "t5.clr");
        chk("t5.flags20", bus.flags, 6'h20);

        // Lone u5 word at an empty queue with out_rdy high.
        do_reset();
        step(3'b100, 14'h0, 14'h0, 14'h0100, 1'b1, 1'b0, "t6.lone");
`ifdef FPRET_BYPASS_EN
        chk("t6.count_stays0", bus.count, 4'd0);
`else
        chk("t6.count1", bus.count, 4'd1);
        chk("t6.ret", bus.out_ret, 16'h8100);
`endif

        // Asynchronous reset in the middle of a burst.
        step(3'b111, 14'h0AAA, 14'h1555, 14'h003F, 1'b0, 1'b0, "t6.burst");
        @(negedge clk);
        bus.u1_ret = 14'h0001; bus.u1_ret_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_mid.vld",   bus.out_vld, 1'b0);
        chk("rst_mid.ret",   bus.out_ret, 16'h0000);
        chk("rst_mid.count", bus.count,   4'd0);
        chk("rst_mid.stall", bus.stall,   1'b0);
        chk("rst_mid.flags", bus.flags,   6'h00);
        chk("rst_mid.ovf",   bus.ovf,     1'b0);
        do_reset();
        check_all("rst_mid.after");

        // Random traffic: a back-pressured phase then a draining phase.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] en;
            logic rdy;
            en  = 3'($urandom_range(0, 7));
            rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(en, 14'($urandom), 14'($urandom), 14'($urandom), rdy,
                 $urandom_range(0, 15) == 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
